mem_access_stage: RTL and testbench

MEM stage of the RV32 five-stage pipeline. It sits between the EX/MEM register and the MEM/WB register, and drives the data memory through a req/gnt/rvalid handshake. It forms byte enables and aligned store data, and sign- or zero-extends load data into loaddata_o, which feeds the MEM/WB loaddata input. It stalls the pipeline while an access is outstanding, and a watchdog aborts accesses that hang.

---
 rtl/mem_access_stage.sv | 185 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32 MEM stage driving a req/gnt/rvalid data-memory port, with load extension and a watchdog.
// Define MEM_MISALIGN_EXC_EN to flag misaligned halfword/word accesses instead of issuing them.
module mem_access_stage #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [3:0]  dm_be_o,
  output logic [31:0] dm_wdata_o,
  input  logic        dm_gnt_i,
  input  logic        dm_rvalid_i,
  input  logic [31:0] dm_rdata_i,
  output logic [31:0] loaddata_o,
  output logic        mem_stall_o,
  output logic        bus_err_o,
  output logic        misalign_o
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0]       lat_funct3;
  logic [1:0]       lat_offset;
  logic             lat_load;

  logic is_load, is_store, load_legal, store_legal;
  logic access, misaligned, start, expired;
  logic req, stall, abort, flag_misalign;
  logic [3:0]  be;
  logic [31:0] wdata;

  // A load wins when both strobes are set.
  assign is_load     = mem_read_i;
  assign is_store    = mem_write_i & ~mem_read_i;
  assign load_legal  = funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign store_legal = funct3_i inside {3'b000, 3'b001, 3'b010};
  assign access      = (is_load & load_legal) | (is_store & store_legal);

`ifdef MEM_MISALIGN_EXC_EN
  assign misaligned = access &
                      (((funct3_i[1:0] == 2'b01) & addr_i[0]) |
                       ((funct3_i[1:0] == 2'b10) & (|addr_i[1:0])));
`else
  assign misaligned = 1'b0;
`endif

  assign start   = access & ~misaligned;
  assign expired = (wait_cnt >= EXPIRE_AT);

  always_comb begin
    be    = 4'b1111;
    wdata = store_data_i;
    if (is_store) begin
      unique case (funct3_i[1:0])
        2'b00: begin
          be    = 4'b0001 << addr_i[1:0];
          wdata = {4{store_data_i[7:0]}};
        end
        2'b01: begin
          be    = addr_i[1] ? 4'b1100 : 4'b0011;
          wdata = {2{store_data_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_next    = state;
    req           = 1'b0;
    stall         = 1'b0;
    abort         = 1'b0;
    flag_misalign = 1'b0;
    unique case (state)
      IDLE: begin
        flag_misalign = misaligned;
        if (start) begin
          req   = 1'b1;
          stall = 1'b1;
          if (dm_gnt_i) state_next = is_load ? WAIT_R : DONE;
          else          state_next = REQ;
        end
      end
      REQ: begin
        req   = 1'b1;
        stall = 1'b1;
        // A grant in the expiry cycle beats the abort.
        if (dm_gnt_i) begin
          state_next = lat_load ? WAIT_R : DONE;
        end else if (expired) begin
          abort      = 1'b1;
          state_next = DONE;
        end
      end
      WAIT_R: begin
        stall = 1'b1;
        if (dm_rvalid_i) begin
          state_next = DONE;
        end else if (expired) begin
          abort      = 1'b1;
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      lat_funct3 <= '0;
      lat_offset <= '0;
      lat_load   <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state == REQ || state == WAIT_R) ? wait_cnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        lat_funct3 <= funct3_i;
        lat_offset <= addr_i[1:0];
        lat_load   <= is_load;
      end
    end
  end

  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  offset);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] result;
    unique case (offset)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];
    unique case (f3)
      3'b000:  result = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  result = {{16{half_sel[15]}}, half_sel};
      3'b100:  result = {24'b0, byte_sel};
      3'b101:  result = {16'b0, half_sel};
      default: result = word;
    endcase
    return result;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaddata_o <= '0;
    end else if (state == WAIT_R && dm_rvalid_i) begin
      loaddata_o <= extend_load(dm_rdata_i, lat_funct3, lat_offset);
    end else if (abort) begin
      loaddata_o <= '0;
    end
  end

  // NOTE: status outputs are also gated by rst_n so reset silences them even while IDLE decodes a requesting instruction.
  assign dm_req_o    = rst_n & req;
  assign mem_stall_o = rst_n & stall;
  assign bus_err_o   = rst_n & abort;
  assign misalign_o  = rst_n & flag_misalign;

  assign dm_we_o    = is_store;
  assign dm_addr_o  = {addr_i[31:2], 2'b00};
  assign dm_be_o    = be;
  assign dm_wdata_o = wdata;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, random accesses against a
// transaction-level model, and hand-written reset/misalignment sequences (MAX_WAIT = 5 here).
`timescale 1ns/1ps
module tb_mem_access_stage;
  localparam int unsigned MAX_WAIT = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, store_data_i;
  logic        dm_req_o, dm_we_o;
  logic [31:0] dm_addr_o;
  logic [3:0]  dm_be_o;
  logic [31:0] dm_wdata_o;
  logic        dm_gnt_i, dm_rvalid_i;
  logic [31:0] dm_rdata_i;
  logic [31:0] loaddata_o;
  logic        mem_stall_o, bus_err_o, misalign_o;

  always #5 clk = ~clk;

  mem_access_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .store_data_i(store_data_i),
    .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o),
    .dm_be_o(dm_be_o), .dm_wdata_o(dm_wdata_o),
    .dm_gnt_i(dm_gnt_i), .dm_rvalid_i(dm_rvalid_i), .dm_rdata_i(dm_rdata_i),
    .loaddata_o(loaddata_o), .mem_stall_o(mem_stall_o),
    .bus_err_o(bus_err_o), .misalign_o(misalign_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_ld;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // g = cycle index of gnt (0 = first request cycle), r = cycles from gnt to rvalid.
  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          g, r;
    int          exp_stalls;
    logic        exp_err;
    int          err_cycle;
    logic        exp_req, exp_mis, exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_ld;
  } vec_t;

  function automatic vec_t tv(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int g, input int r, input logic [31:0] rdata,
                              input int stalls, input logic err, input logic [3:0] be,
                              input logic [31:0] wexp, input logic [31:0] ld);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.g = g; v.r = r; v.rdata = rdata;
    v.exp_stalls = stalls; v.exp_err = err; v.err_cycle = err ? stalls - 1 : -1;
    v.exp_req = (stalls > 0); v.exp_mis = 1'b0; v.exp_we = wr & ~rd;
    v.exp_be = be; v.exp_wdata = wexp; v.exp_ld = ld;
    return v;
  endfunction

  // Transaction-level reference: decides outcome from access size, response timing and wait budget.
  function automatic vec_t predict(input vec_t v_in, input logic [31:0] prev_ld);
    vec_t v;
    int size, off, deadline, resp, abort_at;
    logic legal, mis;
    logic [31:0] val;
    v = v_in;
    size = 1 << v.f3[1:0];
    if (v.rd)      legal = v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    else if (v.wr) legal = (v.f3 < 3'd3);
    else           legal = 1'b0;
    off = int'(v.addr[1:0]) & ~(size - 1);
    mis = 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
    mis = legal && ((int'(v.addr[1:0]) % size) != 0);
`endif
    v.exp_mis = mis; v.exp_we = v.wr & ~v.rd; v.exp_req = legal & ~mis;
    v.exp_err = 1'b0; v.err_cycle = -1; v.exp_ld = prev_ld;
    v.exp_be = 4'hF; v.exp_wdata = v.wdata;
    if (!v.rd && size < 4) begin
      v.exp_be    = 4'(((1 << size) - 1) << off);
      v.exp_wdata = (size == 1) ? {4{v.wdata[7:0]}} : {2{v.wdata[15:0]}};
    end
    if (!v.exp_req) begin
      v.exp_stalls = 0;
    end else begin
      deadline = (v.rd && v.g == int'(MAX_WAIT)) ? int'(MAX_WAIT) + 1 : int'(MAX_WAIT);
      resp = v.rd ? v.g + v.r : v.g;
      if (v.g <= int'(MAX_WAIT) && resp <= deadline) begin
        v.exp_stalls = resp + 1;
        if (v.rd) begin
          val = v.rdata >> (8 * off);
          if (size == 1)      val = v.f3[2] ? {24'b0, val[7:0]}  : {{24{val[7]}}, val[7:0]};
          else if (size == 2) val = v.f3[2] ? {16'b0, val[15:0]} : {{16{val[15]}}, val[15:0]};
          v.exp_ld = val;
        end
      end else begin
        abort_at = (v.g > int'(MAX_WAIT)) ? int'(MAX_WAIT) : deadline;
        v.exp_stalls = abort_at + 1;
        v.exp_err = 1'b1; v.err_cycle = abort_at; v.exp_ld = '0;
      end
    end
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    int stalls = 0;
    int errs = 0;
    int err_at = -1;
    logic done = 1'b0;
    mem_read_i = v.rd; mem_write_i = v.wr; funct3_i = v.f3;
    addr_i = v.addr; store_data_i = v.wdata; dm_rdata_i = v.rdata;
    for (int c = 0; c < 40 && !done; c++) begin
      dm_gnt_i    = (c == v.g);
      dm_rvalid_i = v.rd && (c == v.g + v.r);
      #1;
      if (c == 0) begin
        check({tag, " req"}, 32'(dm_req_o), 32'(v.exp_req));
        check({tag, " misalign"}, 32'(misalign_o), 32'(v.exp_mis));
        if (v.exp_req) begin
          check({tag, " addr"}, dm_addr_o, {v.addr[31:2], 2'b00});
          check({tag, " we"}, 32'(dm_we_o), 32'(v.exp_we));
          check({tag, " be"}, 32'(dm_be_o), 32'(v.exp_be));
          if (v.exp_we) check({tag, " wdata"}, dm_wdata_o, v.exp_wdata);
        end
      end
      if (!mem_stall_o) begin
        done = 1'b1;
      end else begin
        if (c > 0) check($sformatf("%s req@%0d", tag, c), 32'(dm_req_o), 32'(c <= v.g));
        if (bus_err_o) begin errs++; err_at = c; end
        stalls++;
        @(posedge clk); #1;
      end
    end
    dm_gnt_i = 1'b0; dm_rvalid_i = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: stall still high after 40 cycles, required low", tag);
      rst_n = 1'b0; #1; rst_n = 1'b1;
    end else begin
      check({tag, " stall cycles"}, 32'(stalls), 32'(v.exp_stalls));
      check({tag, " bus_err pulses"}, 32'(errs), v.exp_err ? 32'd1 : 32'd0);
      if (v.exp_err) check({tag, " bus_err cycle"}, 32'(err_at), 32'(v.err_cycle));
      check({tag, " req after"}, 32'(dm_req_o), 32'd0);
      check({tag, " loaddata"}, loaddata_o, v.exp_ld);
    end
    @(posedge clk); #1;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    rst_n = 1'b0;
    mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010;
    addr_i = 32'h102; store_data_i = '0;
    dm_gnt_i = 1'b1; dm_rvalid_i = 1'b0; dm_rdata_i = '0;
    #12;
    check("reset req", 32'(dm_req_o), 32'd0);
    check("reset stall", 32'(mem_stall_o), 32'd0);
    check("reset loaddata", loaddata_o, 32'd0);
    check("reset bus_err", 32'(bus_err_o), 32'd0);
    check("reset misalign", 32'(misalign_o), 32'd0);
    @(posedge clk); #1;
    mem_read_i = 1'b0; dm_gnt_i = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    model_ld = '0;

    //          rd    wr    f3      addr          wdata         g   r  rdata         st err be     wdata exp     loaddata
    tbl.push_back(tv(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1, 32'h0,         1, 0, 4'hF, 32'hDEAD_BEEF, 32'h0));
    tbl.push_back(tv(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 0, 1, 32'h0,         1, 0, 4'h8, 32'hA5A5_A5A5, 32'h0));
    tbl.push_back(tv(1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0,         0, 1, 32'h80FF_7F01, 2, 0, 4'hF, 32'h0,         32'hFFFF_FFFF));
    tbl.push_back(tv(1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0,         0, 1, 32'h80FF_7F01, 2, 0, 4'hF, 32'h0,         32'h0000_00FF));
    tbl.push_back(tv(1'b1, 1'b0, 3'b001, 32'h0000_0000, 32'h0,         3, 2, 32'h1234_8001, 6, 0, 4'hF, 32'h0,         32'hFFFF_8001));
    tbl.push_back(tv(1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0,         0, 1, 32'h1234_8001, 2, 0, 4'hF, 32'h0,         32'h0000_1234));
    tbl.push_back(tv(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0,        99, 1, 32'h1111_1111, 6, 1, 4'hF, 32'h0,         32'h0));
    tbl.push_back(tv(1'b1, 1'b1, 3'b010, 32'h0000_0200, 32'h5555_5555, 1, 1, 32'hCAFE_F00D, 3, 0, 4'hF, 32'h0,         32'hCAFE_F00D));
    tbl.push_back(tv(1'b1, 1'b0, 3'b011, 32'h0000_0010, 32'h0,         0, 1, 32'h2222_2222, 0, 0, 4'hF, 32'h0,         32'hCAFE_F00D));
    tbl.push_back(tv(1'b0, 1'b1, 3'b100, 32'h0000_0020, 32'h3333_3333, 0, 1, 32'h0,         0, 0, 4'hF, 32'h0,         32'hCAFE_F00D));
    tbl.push_back(tv(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 5, 1, 32'h0,         6, 0, 4'hC, 32'hBEEF_BEEF, 32'hCAFE_F00D));
    tbl.push_back(tv(1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_0077, 6, 1, 32'h0,         6, 1, 4'h2, 32'h7777_7777, 32'h0));
    tbl.push_back(tv(1'b1, 1'b0, 3'b010, 32'h0000_0080, 32'h0,         5, 1, 32'h0BAD_C0DE, 7, 0, 4'hF, 32'h0,         32'h0BAD_C0DE));
    tbl.push_back(tv(1'b1, 1'b0, 3'b000, 32'h0000_0081, 32'h0,         5, 2, 32'h0000_8000, 7, 1, 4'hF, 32'h0,         32'h0));
    foreach (tbl[i]) begin
      apply(tbl[i], $sformatf("vec%0d", i));
      model_ld = tbl[i].exp_ld;
    end

    for (int i = 0; i < 80; i++) begin
      rv.rd = 1'($urandom_range(0, 1)); rv.wr = 1'($urandom_range(0, 1));
      rv.f3 = 3'($urandom_range(0, 7)); rv.addr = $urandom;
      rv.wdata = $urandom; rv.rdata = $urandom;
      rv.g = $urandom_range(0, 7); rv.r = $urandom_range(1, 3);
      rv = predict(rv, model_ld);
      apply(rv, $sformatf("rnd%0d", i));
      model_ld = rv.exp_ld;
    end

    apply(tv(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0, 1, 32'h1357_9BDF, 2, 0, 4'hF, 32'h0, 32'h1357_9BDF), "pre-reset");
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h304; dm_gnt_i = 1'b1;
    #1 check("mid req", 32'(dm_req_o), 32'd1);
    @(posedge clk); #1;
    dm_gnt_i = 1'b0;
    #1 check("wait_r stall", 32'(mem_stall_o), 32'd1);
    check("wait_r req", 32'(dm_req_o), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async reset req", 32'(dm_req_o), 32'd0);
    check("async reset stall", 32'(mem_stall_o), 32'd0);
    check("async reset loaddata", loaddata_o, 32'd0);
    @(posedge clk); #1;
    mem_read_i = 1'b0; rst_n = 1'b1; dm_rvalid_i = 1'b1; dm_rdata_i = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dm_rvalid_i = 1'b0;
    check("post reset stall", 32'(mem_stall_o), 32'd0);
    check("post reset loaddata", loaddata_o, 32'd0);
    apply(tv(1'b0, 1'b1, 3'b010, 32'h400, 32'h0102_0304, 0, 1, 32'h0, 1, 0, 4'hF, 32'h0102_0304, 32'h0), "post-reset sw");

`ifdef MEM_MISALIGN_EXC_EN
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h102;
    #1;
    check("misalign pulse", 32'(misalign_o), 32'd1);
    check("misalign req", 32'(dm_req_o), 32'd0);
    check("misalign stall", 32'(mem_stall_o), 32'd0);
    @(posedge clk); #1;
    mem_read_i = 1'b0;
    #1;
    check("misalign clear", 32'(misalign_o), 32'd0);
    check("misalign loaddata", loaddata_o, 32'd0);
`else
    apply(tv(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 1, 32'hA1B2_C3D4, 2, 0, 4'hF, 32'h0, 32'hA1B2_C3D4), "lw unaligned");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation still running, required to finish");
    $fatal(1, "timeout");
  end

endmodule
